// File: rtl/gpio_in_port.sv
// GPIO input port: two-flop synchroniser, per-bit debounce, sticky change flags,
// interrupt mask and a single-cycle request / registered-ack register interface.
module gpio_in_port #(
   parameter int WIDTH    = 8,
   parameter int DB_TICKS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gpio_pins,
   input  logic             tick,
   input  logic             req,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             ack,
   output logic             irq
);

   localparam logic [7:0] DB_TICKS_C = 8'(DB_TICKS);
   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_FLAGS = 2'd1;
   localparam logic [1:0] ADDR_MASK  = 2'd2;

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] stable_r;
   logic [WIDTH-1:0] flags_r;
   logic [WIDTH-1:0] mask_r;
   logic [7:0]       cnt_r [WIDTH];

   logic [7:0]       cnt_nxt_s [WIDTH];
   logic [WIDTH-1:0] stable_nxt_s;
   logic [WIDTH-1:0] flags_nxt_s;
   logic [WIDTH-1:0] mask_nxt_s;
   logic [WIDTH-1:0] w1c_s;
   logic [31:0]      rd_mux_s;
   logic             wr_s;
   logic             rd_s;
   logic             unused_wdata_s;

   assign wr_s = req & we;
   assign rd_s = req & ~we;
   // Bits of wdata above WIDTH-1 carry no meaning for this port.
   assign unused_wdata_s = ^wdata;

   // Debounce: a differing synchronised bit must persist for DB_TICKS ticks.
   always_comb begin
      stable_nxt_s = stable_r;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         if (sync2_r[i] == stable_r[i]) begin
            cnt_nxt_s[i] = 8'd0;
         end else if (tick) begin
            if (cnt_r[i] + 8'd1 == DB_TICKS_C) begin
               stable_nxt_s[i] = sync2_r[i];
               cnt_nxt_s[i]    = 8'd0;
            end else begin
               cnt_nxt_s[i] = cnt_r[i] + 8'd1;
            end
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // Register writes, read mux and flag update; a new edge overrides a same-cycle W1C.
   always_comb begin
      w1c_s       = {WIDTH{1'b0}};
      mask_nxt_s  = mask_r;
      rd_mux_s    = 32'd0;
      flags_nxt_s = flags_r;
      if (wr_s && (addr == ADDR_FLAGS)) begin
         w1c_s = wdata[WIDTH-1:0];
      end else begin
         w1c_s = {WIDTH{1'b0}};
      end
      if (wr_s && (addr == ADDR_MASK)) begin
         mask_nxt_s = wdata[WIDTH-1:0];
      end else begin
         mask_nxt_s = mask_r;
      end
      case (addr)
         ADDR_DATA:  rd_mux_s = 32'(stable_r);
         ADDR_FLAGS: rd_mux_s = 32'(flags_r);
         ADDR_MASK:  rd_mux_s = 32'(mask_r);
         default:    rd_mux_s = 32'd0;
      endcase
      flags_nxt_s = (flags_r & ~w1c_s) | (stable_nxt_s ^ stable_r);
   end

   // Input path state: synchroniser, debounce counters and stable value.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r  <= {WIDTH{1'b0}};
         sync2_r  <= {WIDTH{1'b0}};
         stable_r <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= 8'd0;
         end
      end else begin
         sync1_r  <= gpio_pins;
         sync2_r  <= sync1_r;
         stable_r <= stable_nxt_s;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   // Bus-visible state and registered outputs; read data uses pre-update state.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_r <= {WIDTH{1'b0}};
         mask_r  <= {WIDTH{1'b0}};
         rdata   <= 32'd0;
         ack     <= 1'b0;
         irq     <= 1'b0;
      end else begin
         flags_r <= flags_nxt_s;
         mask_r  <= mask_nxt_s;
         ack     <= req;
         rdata   <= rd_s ? rd_mux_s : 32'd0;
         irq     <= |(flags_r & mask_r);
      end
   end

endmodule

// File: tb/tb_gpio_in_port.sv
// Self-checking bench for gpio_in_port: expected read data is queued when a
// request is driven and popped when the matching ack is sampled.
module tb_gpio_in_port;

   logic        clk;
   logic        reset;
   logic [7:0]  gpio_pins;
   logic        tick;
   logic        req;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        irq;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   gpio_in_port #(.WIDTH(8), .DB_TICKS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .gpio_pins (gpio_pins),
      .tick      (tick),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ack       (ack),
      .irq       (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic put_read(input logic [1:0] a, input logic [31:0] e);
      req = 1'b1; we = 1'b0; addr = a; wdata = 32'd0;
      exp_q.push_back(e);
   endtask

   task automatic put_write(input logic [1:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      exp_q.push_back(32'd0);
   endtask

   task automatic put_idle();
      req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; gpio_pins = 8'h00;
      put_idle();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; tick = 1'b1; gpio_pins = 8'h00;
      req = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b want=0", ack); end
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h want=0", rdata); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b want=0", irq); end
      reset = 1'b0;
      put_idle();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL rst_req_no_ack got=%b want=0", ack); end
      put_read(2'd0, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (ack !== 1'b1) begin errors++; $display("FAIL rst_read_ack i=%0d got=%b want=1", i, ack); end
         exp_v = exp_q.pop_front();
         checks++;
         if (rdata !== exp_v) begin errors++; $display("FAIL rst_read i=%0d got=%h want=%h", i, rdata, exp_v); end
         if (i < 4) put_read(2'(i), 32'd0);
         else put_idle();
      end
   endtask

   // stable updates 6 edges after the change; a read at edge j sees it only for j >= 7
   task automatic test_debounce_value();
      gpio_pins = 8'hA5;
      put_read(2'd0, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++;
         if (ack !== 1'b1) begin errors++; $display("FAIL deb_ack i=%0d got=%b want=1", i, ack); end
         exp_v = exp_q.pop_front();
         checks++;
         if (rdata !== exp_v) begin errors++; $display("FAIL deb_read i=%0d got=%h want=%h", i, rdata, exp_v); end
         if (i < 7) put_read(2'd0, (i + 1 >= 7) ? 32'h0000_00A5 : 32'd0);
         else if (i == 7) put_read(2'd1, 32'h0000_00A5);
         else put_idle();
      end
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || rdata !== 32'd0) begin
         errors++; $display("FAIL deb_idle ack=%b rdata=%h want ack=0 rdata=0", ack, rdata);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      put_write(2'd2, 32'h0000_00FF);
      @(negedge clk);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL gl_mask_ack got=%b want=1", ack); end
      exp_v = exp_q.pop_front();
      put_idle();
      gpio_pins = 8'h01;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 3) gpio_pins = 8'h00;
         checks++;
         if (irq !== 1'b0) begin errors++; $display("FAIL gl_irq i=%0d got=%b want=0", i, irq); end
      end
      put_read(2'd0, 32'd0);
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (ack !== 1'b1 || rdata !== exp_v) begin
            errors++; $display("FAIL gl_read i=%0d ack=%b got=%h want=%h", i, ack, rdata, exp_v);
         end
         if (i == 1) put_read(2'd1, 32'd0);
         else put_idle();
      end
   endtask

   task automatic test_irq();
      put_write(2'd2, 32'hFFFF_FF01);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (ack !== 1'b1 || rdata !== exp_v) begin
         errors++; $display("FAIL irq_mask_wr ack=%b got=%h want=%h", ack, rdata, exp_v);
      end
      put_idle();
      gpio_pins = 8'h01;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         checks++;
         if (irq !== (i >= 7)) begin errors++; $display("FAIL irq_rise i=%0d got=%b want=%b", i, irq, (i >= 7)); end
      end
      put_write(2'd1, 32'h0000_0001);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (ack !== 1'b1 || rdata !== exp_v) begin
         errors++; $display("FAIL irq_w1c_ack ack=%b got=%h want=%h", ack, rdata, exp_v);
      end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b want=1", irq); end
      put_read(2'd1, 32'd0);
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b want=0", irq); end
      exp_v = exp_q.pop_front();
      checks++;
      if (ack !== 1'b1 || rdata !== exp_v) begin
         errors++; $display("FAIL irq_flags_clr ack=%b got=%h want=%h", ack, rdata, exp_v);
      end
      put_read(2'd0, 32'h0000_0001);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (ack !== 1'b1 || rdata !== exp_v) begin
         errors++; $display("FAIL irq_data ack=%b got=%h want=%h", ack, rdata, exp_v);
      end
      put_idle();
   endtask

   task automatic test_w1c_collision();
      do_reset();
      gpio_pins = 8'h08;
      repeat (5) @(negedge clk);
      put_write(2'd1, 32'h0000_0008);
      for (int i = 6; i <= 9; i++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (ack !== 1'b1 || rdata !== exp_v) begin
            errors++; $display("FAIL w1c_col i=%0d ack=%b got=%h want=%h", i, ack, rdata, exp_v);
         end
         if (i == 6) put_read(2'd1, 32'h0000_0008);
         else if (i == 7) put_write(2'd1, 32'h0000_0008);
         else if (i == 8) put_read(2'd1, 32'd0);
         else put_idle();
      end
   endtask

   task automatic test_back_to_back();
      put_read(2'd0, 32'h0000_0008);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack i=%0d got=%b want=1", i, ack); end
         exp_v = exp_q.pop_front();
         checks++;
         if (rdata !== exp_v) begin errors++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, rdata, exp_v); end
         if (i == 1) put_write(2'd2, 32'h0000_00FF);
         else if (i == 2) put_read(2'd2, 32'h0000_00FF);
         else put_idle();
      end
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL b2b_end_ack got=%b want=0", ack); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      gpio_pins = 8'h10;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      req = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'h0000_00FF;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
         errors++; $display("FAIL rmid_outs ack=%b rdata=%h irq=%b want 0/0/0", ack, rdata, irq);
      end
      reset = 1'b0;
      put_read(2'd0, 32'd0);
      for (int i = 6; i <= 14; i++) begin
         @(negedge clk);
         checks++;
         if (ack !== 1'b1) begin errors++; $display("FAIL rmid_ack i=%0d got=%b want=1", i, ack); end
         exp_v = exp_q.pop_front();
         checks++;
         if (rdata !== exp_v) begin errors++; $display("FAIL rmid_read i=%0d got=%h want=%h", i, rdata, exp_v); end
         if (i < 12) put_read(2'd0, (i + 1 >= 12) ? 32'h0000_0010 : 32'd0);
         else if (i == 12) put_read(2'd2, 32'd0);
         else if (i == 13) put_read(2'd1, 32'h0000_0010);
         else put_idle();
      end
   endtask

   initial begin
      test_reset();
      test_debounce_value();
      test_glitch();
      test_irq();
      test_w1c_collision();
      test_back_to_back();
      test_reset_mid();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
